// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
// ------------------
// N-approach traffic-light phase controller. A prescaler derived from the
// system clock produces a one-cycle tick; every state, timer and lamp update
// happens only on clock edges where that tick is high. Approaches are served
// in turn through green, yellow and an all-red clearance. Optionally, only
// approaches with demand are served, and a flashing-yellow maintenance mode
// can be entered and left at any tick.
//
// Ports:
//   clk            system clock
//   p_reset        asynchronous, active-high reset
//   i_mode_select  1 = flash mode, 0 = normal cycling (sampled on tick)
//   i_skip_en      1 = serve only approaches with demand (sampled on tick)
//   i_demand       per-approach demand flags (sampled on tick)
//   o_green        green lamp per approach
//   o_yellow       yellow lamp per approach
//   o_red          red lamp per approach
//   o_phase_idx    approach currently or most recently served
//   o_tick         one-clock prescaler pulse
module traffic_phase_ctrl #(
   parameter int N_APPR   = 4,
   parameter int CLK_DIV  = 40000000,
   parameter int INIT_S   = 3,
   parameter int GREEN_S  = 6,
   parameter int YELLOW_S = 3,
   parameter int ALLRED_S = 1,
   parameter int FLASH_S  = 3,
   localparam int PIW     = (N_APPR > 1) ? $clog2(N_APPR) : 1
) (
   input  logic              clk,
   input  logic              p_reset,
   input  logic              i_mode_select,
   input  logic              i_skip_en,
   input  logic [N_APPR-1:0] i_demand,
   output logic [N_APPR-1:0] o_green,
   output logic [N_APPR-1:0] o_yellow,
   output logic [N_APPR-1:0] o_red,
   output logic [PIW-1:0]    o_phase_idx,
   output logic              o_tick
);

   // The dwell timer must hold the largest duration minus one.
   localparam int MAX_A = (INIT_S > GREEN_S) ? INIT_S : GREEN_S;
   localparam int MAX_B = (YELLOW_S > ALLRED_S) ? YELLOW_S : ALLRED_S;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAXD  = (MAX_C > FLASH_S) ? MAX_C : FLASH_S;
   localparam int DW    = $clog2(MAXD + 1);
   localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_GREEN,
      ST_YELLOW,
      ST_ALLRED,
      ST_FLASH_ON,
      ST_FLASH_OFF
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [DW-1:0]       r_dwell;
   logic [DW-1:0]       w_nextDwell;
   logic [DW-1:0]       w_limit;
   logic                w_leave;
   logic [PW-1:0]       r_prescale;
   logic                r_tick;
   logic [PIW-1:0]      r_phaseIdx;
   logic [PIW-1:0]      w_nextIdx;
   logic [N_APPR-1:0]   r_green;
   logic [N_APPR-1:0]   r_yellow;
   logic [N_APPR-1:0]   r_red;
   logic [N_APPR-1:0]   w_nextGreen;
   logic [N_APPR-1:0]   w_nextYellow;
   logic [N_APPR-1:0]   w_nextRed;
   logic [N_APPR-1:0]   w_oneHot;

   // Picks the approach that follows the current one. With skipping enabled the
   // scan starts one past the current index and wraps, so the current index is
   // considered last; modulo arithmetic keeps this right for any N_APPR. With no
   // demand anywhere (or skipping off) plain rotation is used.
   function automatic logic [PIW-1:0] selectNext(
      input logic [PIW-1:0]    cur,
      input logic [N_APPR-1:0] dem,
      input logic              useSkip
   );
      int                idx;
      logic              found;
      logic [N_APPR-1:0] shifted;
      idx        = (int'(cur) + 1) % N_APPR;
      selectNext = PIW'(idx);
      found      = 1'b0;
      if (useSkip) begin
         for (int k = 1; k <= N_APPR; k++) begin
            idx     = (int'(cur) + k) % N_APPR;
            shifted = dem >> idx;
            if (!found && shifted[0]) begin
               found      = 1'b1;
               selectNext = PIW'(idx);
            end
         end
      end
      return selectNext;
   endfunction

   // Next-state logic. A flash request wins over any dwell expiry in the normal
   // states, and releasing flash mode goes straight back to the all-red start-up
   // interval. Phase index only moves when INIT or ALLRED hands over to GREEN,
   // so it holds through yellow, clearance and flash.
   always_comb begin
      w_nextState = r_state;
      w_nextIdx   = r_phaseIdx;
      w_limit     = '0;
      case (r_state)
         ST_INIT:      w_limit = DW'(INIT_S - 1);
         ST_GREEN:     w_limit = DW'(GREEN_S - 1);
         ST_YELLOW:    w_limit = DW'(YELLOW_S - 1);
         ST_ALLRED:    w_limit = DW'(ALLRED_S - 1);
         ST_FLASH_ON,
         ST_FLASH_OFF: w_limit = DW'(FLASH_S - 1);
         default:      w_limit = '0;
      endcase
      case (r_state)
         ST_INIT: begin
            if (i_mode_select) begin
               w_nextState = ST_FLASH_ON;
            end else if (r_dwell == w_limit) begin
               w_nextState = ST_GREEN;
               w_nextIdx   = '0;
            end
         end
         ST_GREEN: begin
            if (i_mode_select)             w_nextState = ST_FLASH_ON;
            else if (r_dwell == w_limit)   w_nextState = ST_YELLOW;
         end
         ST_YELLOW: begin
            if (i_mode_select)             w_nextState = ST_FLASH_ON;
            else if (r_dwell == w_limit)   w_nextState = ST_ALLRED;
         end
         ST_ALLRED: begin
            if (i_mode_select) begin
               w_nextState = ST_FLASH_ON;
            end else if (r_dwell == w_limit) begin
               w_nextState = ST_GREEN;
               w_nextIdx   = selectNext(r_phaseIdx, i_demand, i_skip_en);
            end
         end
         ST_FLASH_ON: begin
            if (!i_mode_select)            w_nextState = ST_INIT;
            else if (r_dwell == w_limit)   w_nextState = ST_FLASH_OFF;
         end
         ST_FLASH_OFF: begin
            if (!i_mode_select)            w_nextState = ST_INIT;
            else if (r_dwell == w_limit)   w_nextState = ST_FLASH_ON;
         end
         default: w_nextState = ST_INIT;
      endcase
      // Every transition is to a different state, so a state change is exactly
      // a state entry and restarts the dwell count.
      w_leave     = (w_nextState != r_state);
      w_nextDwell = w_leave ? '0 : (r_dwell + DW'(1));
   end

   // Lamp decode from the next state and index, so the registered lamps change
   // on the same tick edge as the state instead of one tick later.
   always_comb begin
      w_oneHot     = {{(N_APPR-1){1'b0}}, 1'b1} << w_nextIdx;
      w_nextRed    = '1;
      w_nextGreen  = '0;
      w_nextYellow = '0;
      case (w_nextState)
         ST_GREEN: begin
            w_nextGreen = w_oneHot;
            w_nextRed   = ~w_oneHot;
         end
         ST_YELLOW: begin
            w_nextYellow = w_oneHot;
            w_nextRed    = ~w_oneHot;
         end
         ST_FLASH_ON: begin
            w_nextYellow = '1;
            w_nextRed    = '0;
         end
         ST_FLASH_OFF: begin
            w_nextRed = '0;
         end
         default: begin
            w_nextRed = '1;
         end
      endcase
   end

   // Prescaler and tick register run every cycle; the controller state, dwell
   // timer, phase index and lamps only advance on the edge where tick is high.
   always_ff @(posedge clk or posedge p_reset) begin
      if (p_reset) begin
         r_prescale <= '0;
         r_tick     <= 1'b0;
         r_state    <= ST_INIT;
         r_dwell    <= '0;
         r_phaseIdx <= '0;
         r_green    <= '0;
         r_yellow   <= '0;
         r_red      <= '1;
      end else begin
         if (r_prescale == PW'(CLK_DIV - 1)) begin
            r_prescale <= '0;
            r_tick     <= 1'b1;
         end else begin
            r_prescale <= r_prescale + PW'(1);
            r_tick     <= 1'b0;
         end
         if (r_tick) begin
            r_state    <= w_nextState;
            r_dwell    <= w_nextDwell;
            r_phaseIdx <= w_nextIdx;
            r_green    <= w_nextGreen;
            r_yellow   <= w_nextYellow;
            r_red      <= w_nextRed;
         end
      end
   end

   assign o_green     = r_green;
   assign o_yellow    = r_yellow;
   assign o_red       = r_red;
   assign o_phase_idx = r_phaseIdx;
   assign o_tick      = r_tick;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl
// ---------------------
// Directed bench for traffic_phase_ctrl. One instance uses four approaches for
// reset, rotation, skipping, flash and asynchronous reset checks; a second
// instance uses three approaches for the non-power-of-two skip scan and a long
// random run that watches the lamp safety invariant every cycle.
module tb_traffic_phase_ctrl;

   logic       clk;
   logic       p_reset;

   logic       mode4;
   logic       skip4;
   logic [3:0] dem4;
   logic [3:0] green4;
   logic [3:0] yellow4;
   logic [3:0] red4;
   logic [1:0] phase4;
   logic       tick4;

   logic       mode3;
   logic       skip3;
   logic [2:0] dem3;
   logic [2:0] green3;
   logic [2:0] yellow3;
   logic [2:0] red3;
   logic [1:0] phase3;
   logic       tick3;

   int vectors;
   int miscompares;

   traffic_phase_ctrl #(
      .N_APPR(4), .CLK_DIV(2), .INIT_S(1), .GREEN_S(2),
      .YELLOW_S(1), .ALLRED_S(1), .FLASH_S(1)
   ) dut (
      .clk(clk), .p_reset(p_reset),
      .i_mode_select(mode4), .i_skip_en(skip4), .i_demand(dem4),
      .o_green(green4), .o_yellow(yellow4), .o_red(red4),
      .o_phase_idx(phase4), .o_tick(tick4)
   );

   traffic_phase_ctrl #(
      .N_APPR(3), .CLK_DIV(2), .INIT_S(1), .GREEN_S(2),
      .YELLOW_S(1), .ALLRED_S(1), .FLASH_S(1)
   ) dut3 (
      .clk(clk), .p_reset(p_reset),
      .i_mode_select(mode3), .i_skip_en(skip3), .i_demand(dem3),
      .o_green(green3), .o_yellow(yellow3), .o_red(red3),
      .o_phase_idx(phase3), .o_tick(tick3)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // One comparison: counts the vector and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one instance's inputs from a negedge and advances until just past
   // the next tick edge, landing on the following negedge.
   task automatic applyStimulus(input bit sel3, input logic mode, input logic skip,
                                input logic [3:0] dem);
      bit seen;
      if (sel3) begin
         mode3 = mode; skip3 = skip; dem3 = dem[2:0];
      end else begin
         mode4 = mode; skip4 = skip; dem4 = dem;
      end
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         if (sel3 ? tick3 : tick4) seen = 1'b1;
         @(negedge clk);
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL tickTimeout: observed no tick, required one within 8 cycles");
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      clk = 1'b0; p_reset = 1'b1;
      mode4 = 0; skip4 = 0; dem4 = '0;
      mode3 = 0; skip3 = 0; dem3 = '0;

      @(negedge clk); @(negedge clk);
      p_reset = 1'b0;
      checkOutput("rstRed", red4, 4'hF);
      checkOutput("rstGreen", green4, 4'h0);
      checkOutput("rstYellow", yellow4, 4'h0);
      checkOutput("rstTick", tick4, 0);
      checkOutput("rstPhase", phase4, 0);
      @(negedge clk);
      checkOutput("tickCycle1", tick4, 0);
      checkOutput("redCycle1", red4, 4'hF);
      @(negedge clk);
      checkOutput("tickCycle2", tick4, 1);
      checkOutput("redCycle2", red4, 4'hF);

      // Plain rotation.
      applyStimulus(0, 0, 0, 4'h0);                  // tick 1
      checkOutput("t1Green", green4, 4'b0001);
      checkOutput("t1Red", red4, 4'b1110);
      checkOutput("t1Phase", phase4, 0);
      checkOutput("tickLowAfter", tick4, 0);
      applyStimulus(0, 0, 0, 4'h0);                  // tick 2
      checkOutput("t2Green", green4, 4'b0001);
      applyStimulus(0, 0, 0, 4'h0);                  // tick 3
      checkOutput("t3Yellow", yellow4, 4'b0001);
      checkOutput("t3Green", green4, 4'b0000);
      checkOutput("t3Red", red4, 4'b1110);
      applyStimulus(0, 0, 0, 4'h0);                  // tick 4
      checkOutput("t4Red", red4, 4'b1111);
      checkOutput("t4Yellow", yellow4, 4'b0000);
      applyStimulus(0, 0, 0, 4'h0);                  // tick 5
      checkOutput("t5Green", green4, 4'b0010);
      checkOutput("t5Phase", phase4, 1);
      repeat (4) applyStimulus(0, 0, 0, 4'h0);       // tick 9
      checkOutput("t9Green", green4, 4'b0100);
      repeat (4) applyStimulus(0, 0, 0, 4'h0);       // tick 13
      checkOutput("t13Green", green4, 4'b1000);
      checkOutput("t13Phase", phase4, 3);
      repeat (4) applyStimulus(0, 0, 0, 4'h0);       // tick 17
      checkOutput("t17Green", green4, 4'b0001);
      checkOutput("t17Phase", phase4, 0);

      // Demand-actuated skipping.
      repeat (4) applyStimulus(0, 0, 1, 4'b1000);    // tick 21
      checkOutput("skipGreen", green4, 4'b1000);
      checkOutput("skipPhase", phase4, 3);
      repeat (4) applyStimulus(0, 0, 1, 4'b1000);    // tick 25
      checkOutput("skipSelfPhase", phase4, 3);
      repeat (4) applyStimulus(0, 0, 1, 4'b0000);    // tick 29
      checkOutput("noDemPhase0", phase4, 0);
      checkOutput("noDemGreen0", green4, 4'b0001);
      repeat (4) applyStimulus(0, 0, 1, 4'b0000);    // tick 33
      checkOutput("noDemPhase1", phase4, 1);
      repeat (4) applyStimulus(0, 0, 1, 4'b1001);    // tick 37
      checkOutput("multiDemPhase3", phase4, 3);
      repeat (4) applyStimulus(0, 0, 1, 4'b1001);    // tick 41
      checkOutput("wrapDemPhase0", phase4, 0);
      repeat (4) applyStimulus(0, 0, 0, 4'b0000);    // tick 45
      checkOutput("preFlashGreen", green4, 4'b0010);

      // Flash entry during GREEN of approach 1, then alternation.
      applyStimulus(0, 1, 0, 4'h0);
      checkOutput("flashOnYellow", yellow4, 4'hF);
      checkOutput("flashOnRed", red4, 4'h0);
      checkOutput("flashOnGreen", green4, 4'h0);
      checkOutput("flashOnPhase", phase4, 1);
      applyStimulus(0, 1, 0, 4'h0);
      checkOutput("flashOffYellow", yellow4, 4'h0);
      checkOutput("flashOffRed", red4, 4'h0);
      checkOutput("flashOffGreen", green4, 4'h0);
      applyStimulus(0, 1, 0, 4'h0);
      checkOutput("flashOn2Yellow", yellow4, 4'hF);
      applyStimulus(0, 1, 0, 4'h0);
      checkOutput("flashOff2Yellow", yellow4, 4'h0);
      checkOutput("flashOff2Phase", phase4, 1);

      // Flash exit from FLASH_OFF.
      applyStimulus(0, 0, 0, 4'h0);
      checkOutput("exitInitRed", red4, 4'hF);
      checkOutput("exitInitYellow", yellow4, 4'h0);
      applyStimulus(0, 0, 0, 4'h0);
      checkOutput("exitGreen", green4, 4'b0001);
      checkOutput("exitPhase", phase4, 0);

      // A mode pulse that is gone before the tick edge must be ignored.
      mode4 = 1'b1;
      @(negedge clk);
      mode4 = 1'b0;
      applyStimulus(0, 0, 0, 4'h0);
      checkOutput("glitchGreen", green4, 4'b0001);
      checkOutput("glitchYellow", yellow4, 4'h0);
      applyStimulus(0, 0, 0, 4'h0);
      checkOutput("midYellow", yellow4, 4'b0001);

      // Asynchronous reset in YELLOW while tick is high.
      @(negedge clk);
      checkOutput("preRstTick", tick4, 1);
      #2 p_reset = 1'b1;
      #1;
      checkOutput("asyncYelRed", red4, 4'hF);
      checkOutput("asyncYelYellow", yellow4, 4'h0);
      checkOutput("asyncYelTick", tick4, 0);
      checkOutput("asyncYelPhase", phase4, 0);
      @(negedge clk);
      p_reset = 1'b0;

      // Flash straight from INIT, then asynchronous reset in FLASH_OFF.
      applyStimulus(0, 1, 0, 4'h0);
      checkOutput("initFlashYellow", yellow4, 4'hF);
      checkOutput("initFlashRed", red4, 4'h0);
      applyStimulus(0, 1, 0, 4'h0);
      checkOutput("initFlashOff", yellow4, 4'h0);
      #2 p_reset = 1'b1;
      #1;
      checkOutput("asyncFlashRed", red4, 4'hF);
      checkOutput("asyncFlashYellow", yellow4, 4'h0);
      checkOutput("asyncFlashGreen", green4, 4'h0);
      checkOutput("asyncFlashTick", tick4, 0);
      mode4 = 1'b0;
      @(negedge clk);
      p_reset = 1'b0;

      // Three approaches: skip scan wraps with modulo-3 arithmetic.
      applyStimulus(1, 0, 0, 4'h0);                  // tick 1
      checkOutput("n3Green0", green3, 3'b001);
      repeat (4) applyStimulus(1, 0, 0, 4'h0);       // tick 5
      checkOutput("n3Phase1", phase3, 1);
      repeat (4) applyStimulus(1, 0, 0, 4'h0);       // tick 9
      checkOutput("n3Green2", green3, 3'b100);
      checkOutput("n3Phase2", phase3, 2);
      repeat (4) applyStimulus(1, 0, 1, 4'b0100);    // tick 13
      checkOutput("n3SelfPhase", phase3, 2);
      repeat (4) applyStimulus(1, 0, 1, 4'b0001);    // tick 17
      checkOutput("n3WrapGreen", green3, 3'b001);
      checkOutput("n3WrapPhase", phase3, 0);
      repeat (4) applyStimulus(1, 0, 1, 4'b0010);    // tick 21
      checkOutput("n3DemPhase1", phase3, 1);

      // Random demand/mode ticks with the safety invariant checked every cycle.
      for (int it = 0; it < 10000; it++) begin
         mode3 = ($urandom_range(0, 7) == 0);
         skip3 = 1'($urandom_range(0, 1));
         dem3  = 3'($urandom_range(0, 7));
         repeat (2) begin
            @(negedge clk);
            if (red3 != 3'b000) begin
               checkOutput("invGreen", {31'b0, ($countones(green3) <= 1)}, 1);
               checkOutput("invGreenYellow", {31'b0, ($countones(green3 | yellow3) <= 1)}, 1);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
